// File: rtl/wb_sys_regbank_pkg.sv
// Shared word map, status/control bit positions and bus FSM encoding for the
// Wishbone system register bank.
package wb_sys_regbank_pkg;

  localparam logic [5:0] REGIN_BASE  = 6'h00;
  localparam logic [5:0] REGOUT_BASE = 6'h10;
  localparam logic [5:0] FIFO_DATA   = 6'h20;
  localparam logic [5:0] FIFO_STAT   = 6'h21;
  localparam logic [5:0] FIFO_CTRL   = 6'h22;

  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_OVF   = 18;
  localparam int unsigned STAT_UNF   = 19;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;
  localparam int unsigned CTRL_CLR_UNF = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPop  = 2'd1,
    StResp = 2'd2
  } bus_st_e;

endpackage

// File: rtl/sys_sync_fifo.sv
// Single-clock FIFO with flush, occupancy count, registered full/empty flags and
// single-cycle overflow/underflow indications.
module sys_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop      = pop_i & ~empty_q & ~flush_i;
  assign do_push     = push_i & ~flush_i & (~full_q | do_pop);
  assign overflow_o  = push_i & ~flush_i & ~do_push;
  assign underflow_o = pop_i & empty_q & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == (AW+1)'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/wb_sys_regbank.sv
// Wishbone register bank: synchronised status words, byte-writable control words and a
// capture FIFO drained through the bus.
module wb_sys_regbank
  import wb_sys_regbank_pkg::*;
#(
  parameter int unsigned N_IN        = 8,
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [N_IN*32-1:0]  regin,
  output logic [N_OUT*32-1:0] regout,
  input  logic [31:0]       fifo_wr_in,
  input  logic              fifo_wr_en,
  output logic              fifo_full
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  bus_st_e              state_q, state_d;
  logic                 ack_q, ack_d, err_q, err_d;
  logic [31:0]          dat_q, dat_d;
  logic [N_OUT*32-1:0]  regout_q, regout_d;
  logic [N_IN*32-1:0]   sync_q [SYNC_STAGES];
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  logic [5:0]  word;
  logic        is_regin, is_regout, is_fdat, is_fstat, is_fctrl, mapped;
  logic        accept, wr;
  logic        ctrl_wr, flush, clr_ovf, clr_unf;
  logic [31:0] rd_data, stat;
  logic        fifo_pop, fifo_empty, fifo_ovf, fifo_unf;
  logic [31:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic        unused_adr;

  assign word       = wb_adr_i[7:2];
  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  assign is_regin  = word < (REGIN_BASE + 6'(N_IN));
  assign is_regout = (word >= REGOUT_BASE) && (word < (REGOUT_BASE + 6'(N_OUT)));
  assign is_fdat   = word == FIFO_DATA;
  assign is_fstat  = word == FIFO_STAT;
  assign is_fctrl  = word == FIFO_CTRL;
  assign mapped    = is_regin | is_regout | is_fdat | is_fstat | is_fctrl;

  assign accept  = wb_cyc_i & wb_stb_i & (state_q == StIdle);
  assign wr      = accept & wb_we_i & mapped;
  assign ctrl_wr = wr & is_fctrl & wb_sel_i[0];
  assign flush   = ctrl_wr & wb_dat_i[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr & wb_dat_i[CTRL_CLR_OVF];
  assign clr_unf = ctrl_wr & wb_dat_i[CTRL_CLR_UNF];

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  assign ovf_d = fifo_ovf | (ovf_q & ~clr_ovf);
  assign unf_d = fifo_unf | (unf_q & ~clr_unf);

  always_comb begin
    stat              = '0;
    stat[15:0]        = 16'(fifo_count);
    stat[STAT_EMPTY]  = fifo_empty;
    stat[STAT_FULL]   = fifo_full;
    stat[STAT_OVF]    = ovf_q;
    stat[STAT_UNF]    = unf_q;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (word == REGIN_BASE + 6'(k)) rd_data = sync_q[SYNC_STAGES-1][32*k +: 32];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (word == REGOUT_BASE + 6'(k)) rd_data = regout_q[32*k +: 32];
    end
    if (is_fstat) rd_data = stat;
  end

  always_comb begin
    regout_d = regout_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr && (word == REGOUT_BASE + 6'(k))) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_sel_i[b]) regout_d[32*k + 8*b +: 8] = wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_fdat && !wb_we_i) begin
            state_d = StPop;
          end else begin
            state_d = StResp;
            ack_d   = mapped;
            err_d   = ~mapped;
            dat_d   = rd_data;
          end
        end
      end
      StPop: begin
        fifo_pop = 1'b1;
        state_d  = StResp;
        ack_d    = 1'b1;
        dat_d    = fifo_empty ? 32'h0 : fifo_head;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      regout_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      regout_q <= regout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sync_q[0] <= regin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  sys_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .flush_i     (flush),
    .push_i      (fifo_wr_en),
    .data_i      (fifo_wr_in),
    .pop_i       (fifo_pop),
    .data_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (fifo_ovf),
    .underflow_o (fifo_unf)
  );

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign regout   = regout_q;

endmodule

// File: tb/tb_wb_sys_regbank.sv
// Scoreboard bench for wb_sys_regbank: expected responses are queued when a bus
// transfer is issued and compared when ack/err comes back.
module tb_wb_sys_regbank;

  localparam int NI    = 8;
  localparam int NO    = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           wb_cyc, wb_stb, wb_we;
  logic [3:0]     wb_sel;
  logic [31:0]    wb_adr, wb_dat_i, wb_dat_o;
  logic           wb_ack, wb_err;
  logic [NI*32-1:0] regin;
  logic [NO*32-1:0] regout;
  logic [31:0]    fifo_wr_in;
  logic           fifo_wr_en, fifo_full;

  typedef struct {
    string       tag;
    logic        err;
    int          lat;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  wb_sys_regbank #(
    .N_IN        (NI),
    .N_OUT       (NO),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_sel_i   (wb_sel),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .regin      (regin),
    .regout     (regout),
    .fifo_wr_in (fifo_wr_in),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // push_at: cycle index (0 = accept cycle) during which fifo_wr_en is held high; -1 = never.
  task automatic xfer(input string tag, input bit we, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [3:0] sel, input bit exp_err,
                      input int exp_lat, input bit chk_dat, input logic [31:0] exp_dat,
                      input int push_at, input logic [31:0] push_dat);
    exp_t        e;
    int          lat;
    bit          got;
    logic        a_s, e_s;
    logic [31:0] d_s;
    e.tag = tag; e.err = exp_err; e.lat = exp_lat; e.chk_dat = chk_dat; e.dat = exp_dat;
    sb.push_back(e);
    a_s = 1'b0; e_s = 1'b0; d_s = '0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat; wb_sel = sel;
    fifo_wr_en = (push_at == 0);
    fifo_wr_in = push_dat;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (wb_ack || wb_err) begin
        got = 1'b1; a_s = wb_ack; e_s = wb_err; d_s = wb_dat_o;
      end
      fifo_wr_en = (push_at == lat);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; fifo_wr_en = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check({e.tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, ".ack"}, 32'(a_s), 32'(!e.err));
      check({e.tag, ".err"}, 32'(e_s), 32'(e.err));
      check({e.tag, ".lat"}, 32'(lat), 32'(e.lat));
      if (e.chk_dat) check({e.tag, ".dat"}, d_s, e.dat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp,
                    input int lat);
    xfer(tag, 1'b0, adr, 32'h0, 4'hF, 1'b0, lat, 1'b1, exp, -1, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input bit exp_err);
    xfer(tag, 1'b1, adr, dat, sel, exp_err, 1, 1'b0, 32'h0, -1, 32'h0);
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    fifo_wr_in = d;
    fifo_wr_en = 1'b1;
    @(negedge clk);
    fifo_wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_adr = '0; wb_dat_i = '0; fifo_wr_in = '0; fifo_wr_en = 1'b0;
    regin = '0;
    regin[31:0]    = 32'hA5A5_0001;
    regin[191:160] = 32'h5555_0005;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ack", 32'(wb_ack), 32'd0);
    check("rst.err", 32'(wb_err), 32'd0);
    check("rst.dat", wb_dat_o, 32'h0);
    check("rst.rout0", regout[31:0], 32'h0);
    check("rst.rout7", regout[255:224], 32'h0);
    check("rst.full", 32'(fifo_full), 32'd0);
    repeat (4) @(negedge clk);

    for (int i = 0; i < NO; i++) rd($sformatf("t1.rout%0d", i), 32'h40 + 32'(4 * i), 32'h0, 1);
    rd("t1.rin0", 32'h00, 32'hA5A5_0001, 1);
    rd("t1.rin5", 32'h14, 32'h5555_0005, 1);

    wr("t2.wff", 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr("t2.wsel", 32'h40, 32'h1122_3344, 4'b0101, 1'b0);
    check("t2.port0", regout[31:0], 32'hFF22_FF44);
    rd("t2.rb0", 32'h40, 32'hFF22_FF44, 1);
    wr("t2.w7", 32'h5C, 32'hCAFE_0007, 4'hF, 1'b0);
    check("t2.port7", regout[255:224], 32'hCAFE_0007);
    check("t2.port1", regout[63:32], 32'h0);

    xfer("t3.rin8", 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 1, 1'b1, 32'h0, -1, 32'h0);
    wr("t3.w23", 32'h8C, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr("t3.rout8", 32'h60, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr("t3.wro", 32'h00, 32'hDEAD_BEEF, 4'hF, 1'b0);
    check("t3.port0", regout[31:0], 32'hFF22_FF44);
    check("t3.port7", regout[255:224], 32'hCAFE_0007);
    rd("t3.rin0", 32'h00, 32'hA5A5_0001, 1);

    push(32'd1); push(32'd2); push(32'd3);
    rd("t4.stat3", 32'h84, 32'h0000_0003, 1);
    rd("t4.pop1", 32'h80, 32'd1, 2);
    rd("t4.pop2", 32'h80, 32'd2, 2);
    rd("t4.pop3", 32'h80, 32'd3, 2);
    rd("t4.stat0", 32'h84, 32'h0001_0000, 1);

    for (int i = 1; i <= 5; i++) push(32'(i));
    check("t5.full", 32'(fifo_full), 32'd1);
    rd("t5.stat", 32'h84, 32'h0006_0004, 1);
    xfer("t5.pp", 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 2, 1'b1, 32'd1, 1, 32'h55);
    rd("t5.stat2", 32'h84, 32'h0006_0004, 1);
    rd("t5.pop2", 32'h80, 32'd2, 2);
    rd("t5.pop3", 32'h80, 32'd3, 2);
    rd("t5.pop4", 32'h80, 32'd4, 2);
    rd("t5.pop55", 32'h80, 32'h55, 2);

    rd("t6.popemp", 32'h80, 32'h0, 2);
    rd("t6.stat", 32'h84, 32'h000D_0000, 1);
    xfer("t6.ctrl", 1'b1, 32'h88, 32'h7, 4'hF, 1'b0, 1, 1'b0, 32'h0, 0, 32'h99);
    rd("t6.stat2", 32'h84, 32'h0001_0000, 1);
    rd("t6.ctrlrd", 32'h88, 32'h0, 1);
    check("t6.full", 32'(fifo_full), 32'd0);

    push(32'h77);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h80;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t7.ack", 32'(wb_ack), 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t7.ack2", 32'(wb_ack), 32'd0);
    check("t7.err2", 32'(wb_err), 32'd0);
    rd("t7.stat", 32'h84, 32'h0001_0000, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
